// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - shared CDB types and the result-source / broadcast bus interface
package cdb_pkg;
    typedef logic [5:0]  rs_tag_t;
    typedef logic [31:0] word32_t;
    localparam rs_tag_t NO_VAL = '0;
    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;
endpackage

interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_FU = 4
);
    logic    [NUM_FU-1:0] fu_valid_i;
    rs_tag_t [NUM_FU-1:0] fu_tag_i;
    word32_t [NUM_FU-1:0] fu_val_i;
    logic    [NUM_FU-1:0] fu_ready_o;
    cdb_t                 cdb_o;
    logic    [NUM_FU-1:0] grant_o;
    logic                 pending_o;

    modport slave (
        input  fu_valid_i, fu_tag_i, fu_val_i,
        output fu_ready_o, cdb_o, grant_o, pending_o
    );

    modport master (
        output fu_valid_i, fu_tag_i, fu_val_i,
        input  fu_ready_o, cdb_o, grant_o, pending_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-unit result FIFOs with round-robin broadcast onto the CDB
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    cdb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(NUM_FU);
    typedef logic [IW-1:0] idx_t;

    cdb_t            mem   [NUM_FU][FIFO_DEPTH];
    logic [PW-1:0]   head  [NUM_FU];
    logic [PW-1:0]   tail  [NUM_FU];
    logic [CW-1:0]   count [NUM_FU];
    idx_t            rr_ptr;
    idx_t            win;
    logic            found;
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    cdb_t            cdb_q;
    logic [NUM_FU-1:0] grant_q;

    // Ready is derived from registered occupancy only, so a full FIFO stays
    // not-ready even on the cycle it is being drained.
    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            full[i]     = (count[i] == CW'(FIFO_DEPTH));
            nonempty[i] = (count[i] != '0);
            push[i]     = bus.fu_valid_i[i] && !full[i] && (bus.fu_tag_i[i] != NO_VAL);
        end
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_FU;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                win   = idx_t'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i] = found && (win == idx_t'(i));
        end
    end

    assign bus.fu_ready_o = reset_i ? '0 : ~full;
    assign bus.pending_o  = |nonempty;
    assign bus.cdb_o      = cdb_q;
    assign bus.grant_o    = grant_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr  <= '0;
            cdb_q   <= '{tag: NO_VAL, val: '0};
            grant_q <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    mem[i][tail[i]] <= '{tag: bus.fu_tag_i[i], val: bus.fu_val_i[i]};
                    tail[i]         <= tail[i] + PW'(1);
                end
                if (pop[i]) begin
                    head[i] <= head[i] + PW'(1);
                end
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            if (found) begin
                cdb_q   <= mem[win][head[win]];
                grant_q <= NUM_FU'(1) << win;
                rr_ptr  <= idx_t'((int'(win) + 1) % NUM_FU);
            end else begin
                cdb_q   <= '{tag: NO_VAL, val: '0};
                grant_q <= '0;
            end
        end
    end
endmodule
